// File: rtl/uart_tx_engine.sv
//------------------------------------------------------------------------------
// uart_tx_engine : valid/ready byte in, framed LSB-first serial out on uart_tx
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  generate
    if ((CLKS_PER_BIT < 2) || (DATA_BITS < 5) || (DATA_BITS > 8) ||
        (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_params
      $error("uart_tx_engine: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 parity_bit, parity_bit_n;
  logic                 tx_n, ready_n, busy_n, done_n;
  logic                 bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    parity_bit_n = parity_bit;

    case (state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n      = S_START;
          shreg_n      = tx_data;
          parity_bit_n = (PARITY == 1) ? ~^tx_data : ^tx_data;
          baud_cnt_n   = '0;
          bit_idx_n    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = S_DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[DATA_BITS-1:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = S_STOP;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            state_n   = S_IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = parity_bit_n;
      default:  tx_n = 1'b1;
    endcase
    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_STOP) && (baud_cnt_n == CNT_LAST) && (bit_idx_n == STOP_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      uart_tx    <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      parity_bit <= parity_bit_n;
      uart_tx    <= tx_n;
      tx_ready   <= ready_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
//------------------------------------------------------------------------------
// tb_uart_tx_engine : four engine variants (none/even/odd parity, 2 stop bits)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_engine;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data [4];
  logic [3:0] valid;
  logic [3:0] ready, line, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_engine #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
        .STOP_BITS    ((g == 3) ? 2 : 1)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (data[g]),
        .tx_valid (valid[g]),
        .tx_ready (ready[g]),
        .uart_tx  (line[g]),
        .tx_busy  (busy[g]),
        .tx_done  (done[g])
      );
    end
  endgenerate

  // Reference model: frame contents and length from the framing rules.
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int stops_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int i);
    return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stops_of(i);
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int i, input int k);
    int ones = 0;
    for (int j = 0; j < 8; j++) ones += int'(d[j]);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (par_of(i) == 2 && k == 9) return logic'(ones % 2);
    if (par_of(i) == 1 && k == 9) return logic'((ones + 1) % 2);
    return 1'b1;
  endfunction

  task automatic send(input int i, input logic [7:0] d, input bit keep,
                      input logic [7:0] next_d, output bit ok);
    data[i]  = d;
    valid[i] = 1'b1;
    ok       = 1'b0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (ready[i]) begin
        @(posedge clk);
        #1;
        if (keep) data[i] = next_d;
        else valid[i] = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) valid[i] = 1'b0;
  endtask

  // Observes one frame: mid-bit samples, start latency, length to tx_done.
  task automatic capture_frame(input int i, output logic [11:0] bits, output int len,
                               output int lat, output bit ready_low, output bit busy_high);
    bits = '1; len = -1; lat = -1; ready_low = 1'b1; busy_high = 1'b1;
    for (int w = 1; w <= 50; w++) begin
      @(negedge clk);
      if (!line[i]) begin
        lat = w;
        break;
      end
    end
    if (lat < 0) return;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      if ((n % CPB) == CPB / 2 && (n / CPB) < 12) bits[n / CPB] = line[i];
      if (ready[i]) ready_low = 1'b0;
      if (!busy[i]) busy_high = 1'b0;
      if (done[i]) begin
        len = n + 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (line[i] !== 1'b1)  begin errors++; $display("FAIL reset_line inst%0d got %b want 1", i, line[i]); end
      if (ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready inst%0d got %b want 1", i, ready[i]); end
      if (busy[i] !== 1'b0)  begin errors++; $display("FAIL reset_busy inst%0d got %b want 0", i, busy[i]); end
      if (done[i] !== 1'b0)  begin errors++; $display("FAIL reset_done inst%0d got %b want 0", i, done[i]); end
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (line[i] !== 1'b1)  begin errors++; $display("FAIL idle_line inst%0d got %b want 1", i, line[i]); end
      if (ready[i] !== 1'b1) begin errors++; $display("FAIL idle_ready inst%0d got %b want 1", i, ready[i]); end
    end
  endtask

  task automatic test_frames(input int i, input int count, input logic [7:0] first);
    logic [11:0] bits;
    logic [7:0]  d;
    int len, lat;
    bit ok, rl, bh;
    for (int t = 0; t < count; t++) begin
      d = (t == 0) ? first : 8'($urandom);
      send(i, d, 1'b0, 8'h00, ok);
      capture_frame(i, bits, len, lat, rl, bh);
      checks += 5;
      if (!ok) begin errors++; $display("FAIL handshake inst%0d data %h not accepted", i, d); end
      if (lat !== 1) begin errors++; $display("FAIL start_latency inst%0d got %0d want 1", i, lat); end
      if (len !== frame_bits(i) * CPB) begin
        errors++; $display("FAIL frame_len inst%0d data %h got %0d want %0d", i, d, len, frame_bits(i) * CPB);
      end
      if (!rl) begin errors++; $display("FAIL ready_low inst%0d got ready=1 during frame want 0", i); end
      if (!bh) begin errors++; $display("FAIL busy_high inst%0d got busy=0 during frame want 1", i); end
      for (int k = 0; k < frame_bits(i); k++) begin
        checks++;
        if (bits[k] !== exp_bit(d, i, k)) begin
          errors++; $display("FAIL frame_bit inst%0d data %h bit%0d got %b want %b", i, d, k, bits[k], exp_bit(d, i, k));
        end
      end
      @(negedge clk);
      checks++;
      if ({done[i], ready[i], busy[i], line[i]} !== 4'b0101) begin
        errors++; $display("FAIL after_done inst%0d got done/ready/busy/line=%b want 0101", i,
                           {done[i], ready[i], busy[i], line[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits;
    int len, lat;
    bit ok, rl, bh;
    send(0, 8'hCC, 1'b1, 8'hF0, ok);
    capture_frame(0, bits, len, lat, rl, bh);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL b2b_handshake got no transfer want transfer"); end
    if (len !== 10 * CPB) begin errors++; $display("FAIL b2b_len1 got %0d want %0d", len, 10 * CPB); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bits[k] !== exp_bit(8'hCC, 0, k)) begin
        errors++; $display("FAIL b2b_bit1 bit%0d got %b want %b", k, bits[k], exp_bit(8'hCC, 0, k));
      end
    end
    @(negedge clk);
    if ({ready[0], line[0]} !== 2'b11) begin
      errors++; $display("FAIL b2b_gap got ready/line=%b want 11", {ready[0], line[0]});
    end
    @(posedge clk);
    #1 valid[0] = 1'b0;
    capture_frame(0, bits, len, lat, rl, bh);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL b2b_latency got %0d want 1", lat); end
    if (len !== 10 * CPB) begin errors++; $display("FAIL b2b_len2 got %0d want %0d", len, 10 * CPB); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bits[k] !== exp_bit(8'hF0, 0, k)) begin
        errors++; $display("FAIL b2b_bit2 bit%0d got %b want %b", k, bits[k], exp_bit(8'hF0, 0, k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit done_seen = 1'b0;
    send(0, 8'hF7, 1'b0, 8'h00, ok);
    repeat (1 + 4 * CPB + 5) @(negedge clk);
    checks += 2;
    if (line[0] !== 1'b0) begin errors++; $display("FAIL abort_pre_line got %b want 0", line[0]); end
    #2 reset = 1'b0;
    #1;
    if ({line[0], busy[0], ready[0]} !== 3'b101) begin
      errors++; $display("FAIL abort_async got line/busy/ready=%b want 101", {line[0], busy[0], ready[0]});
    end
    repeat (4) begin
      @(negedge clk);
      if (done[0]) done_seen = 1'b1;
    end
    reset = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (done[0]) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL abort_done got tx_done=1 want 0"); end
    test_frames(0, 1, 8'h3C);
  endtask

  task automatic test_hold_while_busy();
    logic [11:0] bits;
    logic [7:0]  d1, d2;
    int len, lat;
    bit ok, rl, bh;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    send(1, d1, 1'b0, 8'h00, ok);
    fork
      capture_frame(1, bits, len, lat, rl, bh);
      begin
        repeat (150) begin
          @(posedge clk);
          #1;
          data[1]  = 8'($urandom);
          valid[1] = 1'($urandom);
        end
        data[1]  = d2;
        valid[1] = 1'b1;
      end
    join
    checks += 2;
    if (len !== 11 * CPB) begin errors++; $display("FAIL hold_len got %0d want %0d", len, 11 * CPB); end
    if (!rl) begin errors++; $display("FAIL hold_ready got ready=1 during frame want 0"); end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (bits[k] !== exp_bit(d1, 1, k)) begin
        errors++; $display("FAIL hold_bit data %h bit%0d got %b want %b", d1, k, bits[k], exp_bit(d1, 1, k));
      end
    end
    @(negedge clk);
    checks++;
    if ({ready[1], line[1]} !== 2'b11) begin
      errors++; $display("FAIL hold_gap got ready/line=%b want 11", {ready[1], line[1]});
    end
    @(posedge clk);
    #1 valid[1] = 1'b0;
    capture_frame(1, bits, len, lat, rl, bh);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL hold_accept_latency got %0d want 1", lat); end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (bits[k] !== exp_bit(d2, 1, k)) begin
        errors++; $display("FAIL hold_bit2 data %h bit%0d got %b want %b", d2, k, bits[k], exp_bit(d2, 1, k));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    valid = 4'b0000;
    test_reset();
    test_frames(0, 1, 8'hAA);
    test_frames(0, 4, 8'h00);
    test_frames(1, 1, 8'hCC);
    test_frames(2, 1, 8'hF0);
    test_frames(1, 2, 8'hFF);
    test_frames(2, 2, 8'h01);
    test_frames(3, 1, 8'h55);
    test_frames(3, 2, 8'h80);
    test_back_to_back();
    test_reset_mid_frame();
    test_hold_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial UART transmitter, 8N1 by default: the outbound counterpart of the design's UART receive path.
- Accepts parallel bytes over a valid/ready handshake and serialises them onto uart_tx, LSB first.
- Runs at 100 MHz system clock, 9600 baud by default.
- Sits between top_level's response/echo logic and the uart_tx pin.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit period (100 MHz / 9600, truncated); must be >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has data on tx_data.
- tx_ready  output  1  engine can accept a byte (high only in IDLE).
- uart_tx  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset values (reset low, asynchronous): uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
- All outputs are registered. There is no combinational path from tx_valid to tx_ready or uart_tx.
- Handshake: transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into a shift register and parity is computed from the latched value.
  - Later changes to tx_data have no effect on the frame.
- tx_valid asserted outside IDLE is ignored and not consumed; the producer holds it until tx_ready=1.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
  - IDLE: uart_tx=1, tx_ready=1. On transfer, go to START; uart_tx=0 from the next cycle (latency 1 clk).
  - START: uart_tx=0 for exactly CLKS_PER_BIT cycles.
  - DATA: bit index 0..DATA_BITS-1, LSB first. Each bit is held exactly CLKS_PER_BIT cycles.
  - PARITY: odd gives ~^data, even gives ^data. Held CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses high for the last cycle of STOP; the next cycle is IDLE with tx_ready=1.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 at every bit boundary. Never wraps past the terminal count.
- Frame length: from the first low cycle to the tx_done cycle inclusive, (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: with tx_valid held high, the next start bit begins 2 cycles after tx_done (one IDLE handshake cycle plus one latency cycle). The line stays high between frames.
- Reset mid-frame: the frame is aborted immediately (asynchronously), uart_tx returns high and the latched byte is discarded. After release, operation resumes in IDLE.
- tx_busy=1 from the cycle after a transfer until the cycle after tx_done, i.e. exactly while the state is not IDLE.
- Illegal parameter values fail elaboration via a generate-time check.

Test Plan:
1. Defaults; send 0xAA -> uart_tx sampled at mid-bit gives 0,0,1,0,1,0,1,0,1,1. Start-to-tx_done = 104160 cycles. tx_ready low throughout.
2. CLKS_PER_BIT=16, tx_valid held high with 0xCC then 0xF0 -> two frames, bits 0,00110011,1 and 0,00001111,1. Exactly 1 high IDLE cycle plus 1 latency cycle between tx_done and the second start bit. Two tx_done pulses.
3. CLKS_PER_BIT=16, PARITY=2 with 0xCC gives parity bit 0; PARITY=1 with 0xF0 gives parity bit 1. Frame length is 11*16=176 cycles.
4. CLKS_PER_BIT=16, STOP_BITS=2, send 0x55 -> stop high for 32 cycles; tx_done on cycle 176 of the frame.
5. Assert reset low during DATA bit 3 -> uart_tx=1 and tx_busy=0 within the same cycle (async). No tx_done. A new byte 0x3C afterwards transmits correctly.
6. Change tx_data and toggle tx_valid while busy -> transmitted frame unchanged. The held request is accepted only when tx_ready returns.
